jtkcpu_busif: RTL
=================

# jtkcpu_busif

Byte-wide memory bus interface for the KONAMI CPU core. Sits between the control unit and the external memory bus: it takes opcode-fetch, operand-read, data-read and write requests, runs one or two byte cycles on the external bus with wait-state support, and returns the assembled data word (`mdata`), the latched opcode (`op`) and the `mem_busy` status the control unit stalls on. A timeout watchdog flags a bus error when the external bus never acknowledges.

## Interface
Parameters:
- `TOUT`, 15, number of waiting `cen` cycles per byte before a bus error (4-bit counter range, 1..15)

Ports:
- `rst`  in  1  asynchronous reset, active-high
- `clk`  in  1  system clock
- `cen`  in  1  clock enable; all state advances only when high
- `addr`  in  16  request address
- `wdata`  in  16  write data; 8-bit writes use `[7:0]`
- `fetch`  in  1  opcode fetch request (8-bit read, result also to `op`)
- `rd`  in  1  data/operand read request
- `wrq`  in  1  write request
- `memhi`  in  1  request is 16-bit (big-endian: `addr` = high byte, `addr+1` = low byte)
- `op`  out  8  last fetched opcode
- `mdata`  out  16  read data shift register
- `mem_busy`  out  1  access in progress
- `mem_done`  out  1  one-`cen`-cycle completion pulse
- `bus_err`  out  1  one-`cen`-cycle timeout pulse
- `ext_addr`  out  16  external byte address
- `ext_dout`  out  8  external write byte
- `ext_din`  in  8  external read byte
- `ext_cs`  out  1  external chip select
- `ext_we`  out  1  external write enable
- `ext_ok`  in  1  external byte acknowledge (sampled on `cen`)

## Operation
- States: IDLE, BYTE1, BYTE2.
- IDLE, `cen`, any request: latch kind, size, `wdata`; `ext_addr<=addr`; `ext_cs<=1`; `ext_we<=wrq`; `ext_dout<= memhi ? wdata[15:8] : wdata[7:0]`; timeout counter cleared; go BYTE1.
- Simultaneous requests: priority `wrq` > `rd` > `fetch`; lower ones ignored (not queued). `fetch` is always 8-bit regardless of `memhi`.
- BYTE1/BYTE2, `cen`, `ext_ok=1`: on read, `mdata<={mdata[7:0],ext_din}`; on fetch also `op<=ext_din`.
  - BYTE1 and 16-bit: `ext_addr<=ext_addr+1` (wraps FFFF->0000), `ext_dout<=wdata_latched[7:0]`, counter cleared, go BYTE2.
  - otherwise: `ext_cs<=0`, `ext_we<=0`, `mem_done<=1`, go IDLE.
- BYTE1/BYTE2, `cen`, `ext_ok=0`: counter+1; when counter reaches `TOUT`: `ext_cs<=0`, `ext_we<=0`, `bus_err<=1`, go IDLE; `mdata`, `op` not updated by the aborted byte (byte 1 of a 16-bit read already shifted in stays).
- `mem_busy` = state != IDLE (registered state decode).
- `mem_done`, `bus_err` are high for exactly one `cen` cycle; cleared on the next `cen`.
- 8-bit reads shift: two consecutive 8-bit operand reads leave a big-endian word in `mdata`.

## Timing
- Reset (async, any state, mid-access included): state IDLE, `op=0`, `mdata=0`, `mem_busy=0`, `mem_done=0`, `bus_err=0`, `ext_addr=0`, `ext_dout=0`, `ext_cs=0`, `ext_we=0`, counter 0.
- Zero-wait 8-bit: request sampled at `cen` edge N; `ext_cs` high during cycle N+1; completes at edge N+1; `mem_done` high during N+2. Latency 2 `cen` cycles, `mem_busy` high 1.
- Zero-wait 16-bit: 3 `cen` cycles; `mem_busy` high 2.
- Each wait cycle (`ext_ok=0`) adds one `cen` cycle per byte.
- A new request is accepted in the `mem_done` cycle (back-to-back, no idle gap).
- Requests arriving while `mem_busy` are ignored; requester must hold/reissue.
- `cen=0`: all outputs and state frozen; `ext_ok` ignored.

## Test plan
- Reset, then `fetch`, `addr=0x1234`, `ext_din=0x8E`, `ext_ok=1` -> `ext_addr=0x1234`, `op=0x8E`, `mdata=0x008E`, `mem_done` 2 cycles after request.
- 16-bit read `addr=0xFFFF`, bytes 0xAB then 0xCD -> `ext_addr` 0xFFFF then 0x0000, `mdata=0xABCD`, `mem_busy` high 2 cycles.
- 16-bit write `wdata=0x5A3C`, `addr=0x2000`, 2 wait states on byte 1 -> `ext_we=1`, `ext_dout` 0x5A at 0x2000 then 0x3C at 0x2001, done after 5 cycles.
- Read with `ext_ok` held 0, `TOUT=15` -> `bus_err` pulse after 15 waiting cycles, `ext_cs=0`, `mdata` unchanged, `mem_done` stays 0.
- `wrq`+`rd`+`fetch` together -> only write performed, `op` unchanged; back-to-back read issued in `mem_done` cycle is accepted.
- Assert `rst` during BYTE2 of a 16-bit read -> all outputs to reset values immediately, no `mem_done`; `cen` toggling gaps freeze state.

Source files
------------

// File: rtl/jtkcpu_busif.sv
// Byte-wide external bus sequencer for the KONAMI CPU: runs one or two byte
// cycles per request with wait states, assembles read data and flags timeouts.
module jtkcpu_busif #(
  parameter int TOUT = 15
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        fetch,
  input  logic        rd,
  input  logic        wrq,
  input  logic        memhi,
  output logic [7:0]  op,
  output logic [15:0] mdata,
  output logic        mem_busy,
  output logic        mem_done,
  output logic        bus_err,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  input  logic [7:0]  ext_din,
  output logic        ext_cs,
  output logic        ext_we,
  input  logic        ext_ok
);

  typedef enum logic [1:0] {IDLE, BYTE1, BYTE2} state_t;
  typedef enum logic [1:0] {K_WR, K_RD, K_FETCH} kind_t;

  localparam logic [3:0] TOUT_C = 4'(TOUT);

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        wide_q, wide_d;
  logic [7:0]  wlo_q, wlo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [15:0] mdata_q, mdata_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] eaddr_q, eaddr_d;
  logic [7:0]  edout_q, edout_d;
  logic        cs_q, cs_d;
  logic        we_q, we_d;
  logic [3:0]  cnt_inc;

  assign cnt_inc = cnt_q + 4'd1;

  // Next state assumes a cen edge; the register block applies it only when cen is high.
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    wide_d  = wide_q;
    wlo_d   = wlo_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    mdata_d = mdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    eaddr_d = eaddr_q;
    edout_d = edout_q;
    cs_d    = cs_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (wrq || rd || fetch) begin
          kind_d  = wrq ? K_WR : (rd ? K_RD : K_FETCH);
          // fetch is always a single byte, whatever memhi says
          wide_d  = memhi && (wrq || rd);
          wlo_d   = wdata[7:0];
          eaddr_d = addr;
          edout_d = memhi ? wdata[15:8] : wdata[7:0];
          cs_d    = 1'b1;
          we_d    = wrq;
          cnt_d   = 4'd0;
          state_d = BYTE1;
        end
      end
      BYTE1, BYTE2: begin
        if (ext_ok) begin
          if (kind_q != K_WR) mdata_d = {mdata_q[7:0], ext_din};
          if (kind_q == K_FETCH) op_d = ext_din;
          if (state_q == BYTE1 && wide_q) begin
            eaddr_d = eaddr_q + 16'd1;
            edout_d = wlo_q;
            cnt_d   = 4'd0;
            state_d = BYTE2;
          end else begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TOUT_C) begin
            cs_d    = 1'b0;
            we_d    = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_RD;
      wide_q  <= 1'b0;
      wlo_q   <= 8'd0;
      cnt_q   <= 4'd0;
      op_q    <= 8'd0;
      mdata_q <= 16'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eaddr_q <= 16'd0;
      edout_q <= 8'd0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      kind_q  <= kind_d;
      wide_q  <= wide_d;
      wlo_q   <= wlo_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      mdata_q <= mdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eaddr_q <= eaddr_d;
      edout_q <= edout_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
    end
  end

  assign op       = op_q;
  assign mdata    = mdata_q;
  assign mem_busy = (state_q != IDLE);
  assign mem_done = done_q;
  assign bus_err  = err_q;
  assign ext_addr = eaddr_q;
  assign ext_dout = edout_q;
  assign ext_cs   = cs_q;
  assign ext_we   = we_q;

endmodule
